result_demux: RTL
=================

RESULT_DEMUX -- requirements
Module: result_demux

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data path width in bits.
REQ-002 Parameter CNTW, default 16, SHALL set the width of each per-output transfer counter.
REQ-003 Ports SHALL be as follows; clk and reset are listed first:
- clk  input  1  the single clock; all state SHALL update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of both output buffers (pipeline kill).
- in_data  input  WIDTH  result word to route.
- in_sel  input  1  destination select (0 = port 0, 1 = port 1).
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- out0_data  output  WIDTH  port 0 data.
- out0_valid  output  1  port 0 holds a word.
- out0_ready  input  1  port 0 consumer accepts.
- out1_data  output  WIDTH  port 1 data.
- out1_valid  output  1  port 1 holds a word.
- out1_ready  input  1  port 1 consumer accepts.
- cnt0  output  CNTW  count of completed port 0 output transfers.
- cnt1  output  CNTW  count of completed port 1 output transfers.

Function
REQ-004 The block SHALL be the 1-to-2 inverse of the 2:1 operand select: one input stream, routed by in_sel to exactly one of two registered output ports.
REQ-005 Each port k SHALL have a one-entry buffer with a 2-state FSM: EMPTY (outk_valid=0) and FULL (outk_valid=1).
REQ-006 An input accept SHALL occur when in_valid && in_ready.
REQ-007 An output transfer on port k SHALL occur when outk_valid && outk_ready.
REQ-008 in_ready SHALL be combinational: !rst && !flush && (selected port EMPTY || selected port transferring this cycle).
REQ-009 On an accept, the selected buffer SHALL load in_data and be FULL at the next edge. Latency is 1 cycle: data appears on outk_data in the cycle after the accept.
REQ-010 The unselected port SHALL NOT change on an accept.
REQ-011 Port k FSM transitions:
- EMPTY->FULL on accept with in_sel=k.
- FULL->EMPTY on a transfer with no accept to k.
- FULL->FULL with new data on a simultaneous transfer and accept to k; no bubble, no loss.
REQ-012 outk_data SHALL be held stable while FULL and not transferring. outk_data SHALL retain its last value when EMPTY.
REQ-013 cntk SHALL increment by 1 on each port-k transfer and wrap modulo 2^CNTW (all-ones -> 0).
REQ-014 flush SHALL force both ports EMPTY at the next edge, overriding any same-cycle accept. Counters SHALL not increment for words discarded by flush. A transfer occurring in the flush cycle SHALL still be counted.
REQ-015 Words SHALL leave each port in acceptance order. Both ports SHALL operate independently and may transfer in the same cycle.

Reset
REQ-016 While rst=1 at a clock edge, the block SHALL set out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0, and both FSMs to EMPTY.
REQ-017 in_ready SHALL be 0 during reset.
REQ-018 A reset asserted mid-operation SHALL discard buffered words without counting them.
REQ-019 The first accept SHALL be possible in the first cycle with rst=0.

Verification
REQ-020 Reset then in_valid=1, in_sel=0, in_data=0xDEADBEEF, out0_ready=0 -> next cycle: out0_valid=1, out0_data=0xDEADBEEF, out1_valid=0, and in_ready=0 for in_sel=0, 1 for in_sel=1.
REQ-021 Port 1 FULL with 0x11111111, out1_ready=1, and same-cycle accept of 0x22222222 with in_sel=1 -> next cycle: out1_valid=1, out1_data=0x22222222, cnt1 incremented by 1.
REQ-022 Alternating in_sel 0,1,0,1 with words 1..4 and both readys=1 -> port 0 emits 1,3 and port 1 emits 2,4, each one cycle after accept; cnt0=cnt1=2.
REQ-023 Both ports FULL, flush=1 with in_valid=1 -> in_ready=0; next cycle both valids=0; counters unchanged.
REQ-024 With CNTW=4, 16 port-0 transfers -> cnt0 returns to 0 (wraps).
REQ-025 rst=1 while both ports are FULL and cnt0=5 -> next cycle: all valids=0, data=0, cnt0=cnt1=0.

Source files
------------

// File: rtl/result_demux.sv
// 1-to-2 result router: one input stream steered by in_sel into one of two
// single-entry output buffers, each with its own transfer counter.
module result_demux #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_p1 [2];
    logic [WIDTH-1:0]  data_p1  [2];
    logic [CNTW-1:0]   cnt_p1   [2];

    logic [1:0]        out_ready;
    logic [1:0]        xfer;
    logic [1:0]        acc;

    function automatic logic [CNTW-1:0] cnt_inc(input logic [CNTW-1:0] c);
        return c + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    assign out_ready = {out1_ready, out0_ready};
    assign xfer[0]   = (state_p1[0] == FULL) && out_ready[0];
    assign xfer[1]   = (state_p1[1] == FULL) && out_ready[1];

    // A full buffer may take a new word in the same cycle its current word leaves.
    assign in_ready  = !rst && !flush &&
                       ((state_p1[in_sel] == EMPTY) || xfer[in_sel]);
    assign acc[0]    = in_valid && in_ready && !in_sel;
    assign acc[1]    = in_valid && in_ready &&  in_sel;

    // Stage p1: output buffers and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                state_p1[k] <= EMPTY;
                data_p1[k]  <= '0;
                cnt_p1[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (xfer[k])
                    cnt_p1[k] <= cnt_inc(cnt_p1[k]);
                if (flush) begin
                    state_p1[k] <= EMPTY;
                end else if (acc[k]) begin
                    state_p1[k] <= FULL;
                    data_p1[k]  <= in_data;
                end else if (xfer[k]) begin
                    state_p1[k] <= EMPTY;
                end
            end
        end
    end

    assign out0_valid = (state_p1[0] == FULL);
    assign out1_valid = (state_p1[1] == FULL);
    assign out0_data  = data_p1[0];
    assign out1_data  = data_p1[1];
    assign cnt0       = cnt_p1[0];
    assign cnt1       = cnt_p1[1];

endmodule
